serial_link_driver: RTL and testbench

Bit-serial request driver sitting on the slave side of the four-signal link interface (a, b driven toward the master; c, d returned from it). It accepts a parallel word through a valid/ready handshake, shifts it out LSB-first as per-bit beats (a = beat valid, b = data bit, c = beat ready), then waits for a one-bit response on d. A stall watchdog aborts the transfer with an error flag if the far side stops responding.

---
 rtl/serial_link_driver.sv | 99 +++++++++
 tb/tb_serial_link_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/serial_link_driver.sv
// Bit-serial request driver: accepts a parallel word, shifts it out LSB-first
// as per-bit link beats, then collects a one-bit response, with a stall watchdog.
module serial_link_driver #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_a,
  output logic             o_b,
  input  logic             i_c,
  input  logic             i_d,
  output logic             o_done,
  output logic             o_resp,
  output logic             o_err
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BEAT  = CW'(WIDTH - 1);
  localparam logic [7:0]    STALL_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    beat_cnt;
  logic [7:0]       stall_cnt;

  // Link outputs depend only on registered state so i_c/i_d never reach them.
  assign o_ready = (state == IDLE);
  assign o_a     = (state == SHIFT);
  assign o_b     = (state == SHIFT) & shift_reg[0];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      stall_cnt <= '0;
      o_done    <= 1'b0;
      o_resp    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_resp <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            shift_reg <= i_data;
            beat_cnt  <= '0;
            stall_cnt <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (i_c) begin
            shift_reg <= shift_reg >> 1;
            stall_cnt <= '0;
            // Hold the beat counter on the last beat so it never wraps.
            if (beat_cnt == LAST_BEAT) begin
              state <= RESP;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end else if (stall_cnt == STALL_LAST) begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
            state  <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        RESP: begin
          if (i_c) begin
            o_resp <= i_d;
            o_done <= 1'b1;
            state  <= IDLE;
          end else if (stall_cnt == STALL_LAST) begin
            o_done <= 1'b1;
            o_err  <= 1'b1;
            state  <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_link_driver.sv
// Directed self-checking bench for serial_link_driver (WIDTH=8, TIMEOUT=16).
module tb_serial_link_driver;

  logic       i_clk;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       o_a;
  logic       o_b;
  logic       i_c;
  logic       i_d;
  logic       o_done;
  logic       o_resp;
  logic       o_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  serial_link_driver #(.WIDTH(8), .TIMEOUT(16)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_a    (o_a),
    .o_b    (o_b),
    .i_c    (i_c),
    .i_d    (i_d),
    .o_done (o_done),
    .o_resp (o_resp),
    .o_err  (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Full word with optional stall of stall_len cycles before beat stall_at.
  task automatic xfer(input logic [7:0] w, input logic d, input int stall_at, input int stall_len);
    i_c = 1'b1; i_d = d; i_data = w; i_valid = 1'b1;
    check("accept_ready", o_ready, 1);
    step();
    i_valid = 1'b0;
    i_data  = ~w;
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        i_c = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check("stall_a", o_a, 1);
          check("stall_b", o_b, w[k]);
          step();
        end
        i_c = 1'b1;
      end
      check("beat_a", o_a, 1);
      check("beat_b", o_b, w[k]);
      check("beat_done", o_done, 0);
      step();
    end
    check("resp_a", o_a, 0);
    check("resp_done", o_done, 0);
    step();
    check("done", o_done, 1);
    check("done_resp", o_resp, d);
    check("done_err", o_err, 0);
    check("done_ready", o_ready, 1);
    step();
    check("done_clear", o_done, 0);
  endtask

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_data = 8'h00; i_c = 1'b0; i_d = 1'b0;
    #3;
    check("rst_ready", o_ready, 1);
    check("rst_a", o_a, 0);
    check("rst_b", o_b, 0);
    check("rst_done", o_done, 0);
    check("rst_resp", o_resp, 0);
    check("rst_err", o_err, 0);
    step(); step();
    i_rst = 1'b1;
    step();

    // Single word, i_c tied high
    xfer(8'hA5, 1'b1, -1, 0);

    // Back-to-back with i_valid held high
    i_c = 1'b1; i_d = 1'b0; i_data = 8'h01; i_valid = 1'b1;
    step();
    i_data = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      check("b2b1_a", o_a, 1);
      check("b2b1_b", o_b, k == 0);
      step();
    end
    check("b2b1_resp_ready", o_ready, 0);
    step();
    check("b2b1_done", o_done, 1);
    check("b2b1_ready", o_ready, 1);
    i_d = 1'b1;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("b2b2_a", o_a, 1);
      check("b2b2_b", o_b, k != 0);
      step();
    end
    step();
    check("b2b2_done", o_done, 1);
    check("b2b2_resp", o_resp, 1);
    step();

    // Beat backpressure: 3 stall cycles before beat 4
    xfer(8'h3C, 1'b0, 4, 3);

    // Response timeout
    i_c = 1'b1; i_d = 1'b1; i_data = 8'hC3; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) step();
    i_c = 1'b0;
    for (int s = 0; s < 16; s++) begin
      check("rto_wait_done", o_done, 0);
      step();
    end
    check("rto_done", o_done, 1);
    check("rto_err", o_err, 1);
    check("rto_resp", o_resp, 0);
    check("rto_ready", o_ready, 1);
    step();
    check("rto_clear", o_err, 0);

    // Stall timeout mid-shift after 2 beats
    i_c = 1'b1; i_data = 8'h96; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step(); step();
    i_c = 1'b0;
    for (int s = 0; s < 16; s++) begin
      check("sto_a", o_a, 1);
      check("sto_wait_done", o_done, 0);
      step();
    end
    check("sto_done", o_done, 1);
    check("sto_err", o_err, 1);
    check("sto_a_idle", o_a, 0);
    step();
    xfer(8'h5A, 1'b0, -1, 0);

    // Reset mid-transfer during beat 5
    i_c = 1'b1; i_data = 8'hFF; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("mid_beat5_a", o_a, 1);
    #2;
    i_rst = 1'b0;
    #1;
    check("mid_rst_a", o_a, 0);
    check("mid_rst_b", o_b, 0);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_done", o_done, 0);
    step();
    check("mid_rst_hold_done", o_done, 0);
    i_rst = 1'b1;
    step();
    check("post_rst_done", o_done, 0);
    xfer(8'h81, 1'b1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
